// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between the LED sequencer and its driver.
// Optional LED_STEP_EN adds the single-step request line used while held.
interface led_seq_ctrl_if #(
  parameter int CNT_W = 24
);
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic             dir;
  logic [CNT_W-1:0] div;
  logic [7:0]       q;
  logic             tick;
  logic             cycle_done;
  logic             busy;
`ifdef LED_STEP_EN
  logic             step;

  modport master (output en, clr, mode, dir, div, step,
                  input  q, tick, cycle_done, busy);
  modport slave  (input  en, clr, mode, dir, div, step,
                  output q, tick, cycle_done, busy);
`else
  modport master (output en, clr, mode, dir, div,
                  input  q, tick, cycle_done, busy);
  modport slave  (input  en, clr, mode, dir, div,
                  output q, tick, cycle_done, busy);
`endif
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: prescaled stepping of FILL/RUN/BOUNCE/BLINK under an IDLE/RUN/HOLD FSM.
// Define LED_STEP_EN to allow single-stepping the pattern from HOLD via bus.step.
module led_seq_ctrl #(
  parameter int CNT_W = 24
) (
  input  logic          clk,
  input  logic          rs_n,
  led_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t           st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       stp_q;
  logic [7:0]       pat_q;
  logic [1:0]       mode_q;
  logic             bflag_q;
  logic             tick_q;
  logic             done_q;
  logic             busy_q;

  logic [7:0] pat_d;
  logic [3:0] stp_d;
  logic [1:0] mode_d;
  logic       bflag_d;
  logic       done_d;
  logic [3:0] last_stp;
  logic [7:0] seed;
  logic       adv_hold;

  function automatic logic [7:0] seed_of(input logic [1:0] m, input logic d);
    logic [7:0] s;
    case (m)
      2'd1:    s = d ? 8'h80 : 8'h01;
      2'd2:    s = 8'h01;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Result of one pattern advance, shared by prescaler ticks and HOLD single-steps.
  always_comb begin
    seed    = seed_of(bus.mode, bus.dir);
    pat_d   = pat_q;
    stp_d   = stp_q;
    mode_d  = mode_q;
    bflag_d = bflag_q;
    done_d  = 1'b0;
    case (mode_q)
      2'd0:    last_stp = 4'd15;
      2'd1:    last_stp = 4'd7;
      2'd2:    last_stp = 4'd13;
      default: last_stp = 4'd1;
    endcase
    if (bus.mode != mode_q) begin
      mode_d  = bus.mode;
      pat_d   = seed;
      stp_d   = 4'd0;
      bflag_d = 1'b0;
    end else begin
      done_d = (stp_q == last_stp);
      stp_d  = (stp_q == last_stp) ? 4'd0 : stp_q + 4'd1;
      case (mode_q)
        2'd0: pat_d = bus.dir ? {~pat_q[0], pat_q[7:1]} : {pat_q[6:0], ~pat_q[7]};
        2'd1: pat_d = bus.dir ? {pat_q[0], pat_q[7:1]} : {pat_q[6:0], pat_q[7]};
        2'd2: begin
          // bflag_q=0 travels toward MSB; it flips once the bit lands on an end.
          if (!bflag_q) begin
            pat_d   = {pat_q[6:0], 1'b0};
            bflag_d = pat_d[7];
          end else begin
            pat_d   = {1'b0, pat_q[7:1]};
            bflag_d = ~pat_d[0];
          end
        end
        default: pat_d = ~pat_q;
      endcase
    end
  end

`ifdef LED_STEP_EN
  logic step_prev_q;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) step_prev_q <= 1'b0;
    else       step_prev_q <= bus.step;
  end

  assign adv_hold = bus.step & ~step_prev_q;
`else
  assign adv_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      stp_q   <= 4'd0;
      pat_q   <= 8'h00;
      mode_q  <= 2'd0;
      bflag_q <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.clr) begin
        st_q    <= S_IDLE;
        cnt_q   <= '0;
        stp_q   <= 4'd0;
        pat_q   <= 8'h00;
        bflag_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (st_q)
          S_IDLE: begin
            if (bus.en) begin
              st_q    <= S_RUN;
              busy_q  <= 1'b1;
              pat_q   <= seed;
              mode_q  <= bus.mode;
              stp_q   <= 4'd0;
              cnt_q   <= '0;
              bflag_q <= 1'b0;
            end
          end
          S_RUN: begin
            if (!bus.en) begin
              st_q   <= S_HOLD;
              busy_q <= 1'b0;
            end else if (cnt_q >= bus.div) begin
              cnt_q   <= '0;
              tick_q  <= 1'b1;
              done_q  <= done_d;
              pat_q   <= pat_d;
              stp_q   <= stp_d;
              mode_q  <= mode_d;
              bflag_q <= bflag_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_HOLD: begin
            if (adv_hold) begin
              tick_q  <= 1'b1;
              done_q  <= done_d;
              pat_q   <= pat_d;
              stp_q   <= stp_d;
              mode_q  <= mode_d;
              bflag_q <= bflag_d;
            end
            if (bus.en) begin
              st_q   <= S_RUN;
              busy_q <= 1'b1;
            end
          end
          default: begin
            st_q   <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q          = pat_q;
  assign bus.tick       = tick_q;
  assign bus.cycle_done = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer/controller for the 8-bit LED pattern register driven on the board LED bank.
- Generates the step rate from clk via a programmable prescaler.
- Selects among four shift/rotate patterns and runs, holds or clears them under an enable/clear FSM.
- Flags completion of each full pattern period for the upper-level display logic.

Parameters:
- CNT_W, 24, width of prescaler counter and div port.

Ports:
- clk  in  1  system clock, rising edge.
- rs_n  in  1  reset, asynchronous, active-low. One clock domain; reset is asynchronous and active-low.
- en  in  1  run enable, level.
- clr  in  1  synchronous clear, level, priority over en.
- mode  in  2  pattern select: 0 FILL, 1 RUN, 2 BOUNCE, 3 BLINK.
- dir  in  1  0 = shift toward MSB, 1 = toward LSB (FILL, RUN only).
- div  in  CNT_W  step period minus 1, in clk cycles.
- q  out  8  LED pattern, registered.
- tick  out  1  one-cycle pulse on each pattern step.
- cycle_done  out  1  one-cycle pulse, coincident with tick, when the pattern returns to its seed.
- busy  out  1  high in RUN state.

Behaviour:
- Reset (rs_n=0): FSM=IDLE, q=8'h00, prescaler=0, step count=0, tick=cycle_done=busy=0, mode_q=0, bounce flag=0.
- FSM states and transitions:
  - IDLE: q=00. en=1 -> RUN; the current mode seed is loaded into q on that edge.
  - RUN: prescaler counts. en=0 -> HOLD.
  - HOLD: q, prescaler and step count are frozen. en=1 -> RUN, resuming without reseed.
  - clr=1 from any state -> IDLE next edge: q=00, prescaler=0, step=0. clr overrides en.
- Prescaler:
  - In RUN, increments each clk.
  - When count >= div: tick=1 that cycle, count returns to 0.
  - Step period is div+1 cycles; div=0 gives a tick every cycle.
  - A mid-count div reduction below the current count ticks on the next cycle.
- Step on tick, per mode_q:
  - FILL: Johnson. dir=0: q <= {q[6:0], ~q[7]}; dir=1: q <= {~q[0], q[7:1]}. Seed 00, period 16.
  - RUN: rotate. dir=0 rotate left, dir=1 rotate right. Seed 01 (dir=0) or 80 (dir=1), period 8.
  - BOUNCE: single bit ping-pong 01 -> 80 -> 01 using an internal direction flag. Flag flips when the bit reaches bit 7 or bit 0. Seed 01, period 14; dir is ignored.
  - BLINK: q <= ~q. Seed 00, period 2.
- Mode change:
  - mode is sampled only on tick.
  - If mode != mode_q at a tick: mode_q <= mode, q <= new seed, step=0, bounce flag cleared, cycle_done=0.
  - The mode change consumes that step.
- dir change takes effect at the next step; no reseed.
- Step counter (4-bit) wraps at the mode period. cycle_done=1 on the tick that brings step back to 0.
- tick and cycle_done are registered pulses asserted with the q update; never asserted in IDLE or HOLD.
- busy=1 exactly while FSM=RUN.
- rs_n asserted mid-run returns all state to reset values immediately (asynchronous).

Optional Feature:
- Macro LED_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - A one-cycle step pulse while in HOLD advances the pattern exactly one step, with the same rules as a tick, including mode sampling.
  - tick and cycle_done pulse accordingly.
  - step is ignored in IDLE and RUN.
  - If step is held high, it is edge-detected: one advance per rising edge.
- Undefined: no step port; HOLD is a pure freeze.

Test Plan:
- Reset, then en=1, mode=0, dir=0, div=3 -> ticks every 4 cycles; q = 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; cycle_done on the 16th tick only.
- mode=1, dir=1, div=0 -> q = 80,40,20,...,01,80 one per cycle. Toggle dir to 0 at q=10 -> next q=20.
- mode=2, div=1 -> q 01,02,...,80,40,...,01; period 14 ticks; cycle_done when back at 01.
- Running FILL at q=07, drop en for 10 cycles, then raise it -> q stays 07 and tick=0 during HOLD. Resumes 0F after the remaining prescaler count.
- While running, switch mode 0->3 -> at next tick q=00 with no cycle_done, then FF, 00 with cycle_done every 2 ticks. Assert clr -> q=00, busy=0 next cycle. Pulse rs_n low mid-count -> all outputs 0 immediately.
- (LED_STEP_EN) HOLD at RUN q=04, pulse step twice -> q=08 then 10; step held high 5 cycles -> single advance.
